// File: rtl/vga_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_ctrl_pkg
// Description : Shared widths, framebuffer geometry, fill-engine state
//               encodings, the latched fill operand record and the
//               framebuffer address helper used by the VGA write-port
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_write_ctrl_pkg;

    // Framebuffer write-port geometry
    localparam int VGA_ADDR_WIDTH       = 19;
    localparam int VGA_DATA_WIDTH       = 8;
    localparam int VGA_WIDTH_MULT_SHIFT = 9;    // row stride = 512 addresses

    // Visible framebuffer size in pixels
    localparam int VGA_FB_W = 400;
    localparam int VGA_FB_H = 300;

    // Width of the fill operands and of the column/row counters
    localparam int FILL_CW = 9;

    // Fill engine state encodings
    typedef logic [1:0] fill_state_t;
    localparam fill_state_t VGA_FILL_IDLE = 2'd0;
    localparam fill_state_t VGA_FILL_RUN  = 2'd1;
    localparam fill_state_t VGA_FILL_DONE = 2'd2;

    // Operands captured when a fill is accepted (w/h already effective)
    typedef struct packed {
        logic [FILL_CW-1:0]        x;
        logic [FILL_CW-1:0]        y;
        logic [FILL_CW-1:0]        w;
        logic [FILL_CW-1:0]        h;
        logic [VGA_DATA_WIDTH-1:0] color;
    } fill_op_t;

    // Wide enough for a 10-bit row sum shifted by the stride plus a 10-bit
    // column sum, so nothing is lost before the final truncation.
    localparam int FILL_SUM_W = VGA_ADDR_WIDTH + FILL_CW + VGA_WIDTH_MULT_SHIFT + 2;

    // addr = ((y + row) << shift) + (x + col), truncated to the port width.
    // Sums are formed at 10 bits so large corners never overflow early.
    function automatic logic [VGA_ADDR_WIDTH-1:0] fill_addr(
        input logic [FILL_CW-1:0] y,
        input logic [FILL_CW-1:0] row,
        input logic [FILL_CW-1:0] x,
        input logic [FILL_CW-1:0] col
    );
        logic [FILL_CW:0]    ys;
        logic [FILL_CW:0]    xs;
        logic [FILL_SUM_W-1:0] full;
        ys   = {1'b0, y} + {1'b0, row};
        xs   = {1'b0, x} + {1'b0, col};
        full = (FILL_SUM_W'(ys) << VGA_WIDTH_MULT_SHIFT) + FILL_SUM_W'(xs);
        return full[VGA_ADDR_WIDTH-1:0];
    endfunction

endpackage : vga_write_ctrl_pkg
`default_nettype wire

// File: rtl/vga_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_ctrl_if
// Description : Bus bundle between the CPU glue / fill requester and the
//               VGA write-port controller, plus the registered write port
//               that drives the vga framebuffer.
//   cpu_we/cpu_addr/cpu_data      : CPU pixel write, one per asserted cycle
//   fill_start/fill_x/y/w/h/color : rectangle fill request (start pulse)
//   fill_busy/fill_done           : fill status
//   vga_we/vga_addr/vga_data      : registered framebuffer write port
// Modports    : master (requester side), slave (controller side)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_write_ctrl_if;
    import vga_write_ctrl_pkg::*;

    logic                      cpu_we;
    logic [VGA_ADDR_WIDTH-1:0] cpu_addr;
    logic [VGA_DATA_WIDTH-1:0] cpu_data;

    logic                      fill_start;
    logic [FILL_CW-1:0]        fill_x;
    logic [FILL_CW-1:0]        fill_y;
    logic [FILL_CW-1:0]        fill_w;
    logic [FILL_CW-1:0]        fill_h;
    logic [VGA_DATA_WIDTH-1:0] fill_color;
    logic                      fill_busy;
    logic                      fill_done;

    logic                      vga_we;
    logic [VGA_ADDR_WIDTH-1:0] vga_addr;
    logic [VGA_DATA_WIDTH-1:0] vga_data;

    modport master (
        output cpu_we, cpu_addr, cpu_data,
        output fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
        input  fill_busy, fill_done,
        input  vga_we, vga_addr, vga_data
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_data,
        input  fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
        output fill_busy, fill_done,
        output vga_we, vga_addr, vga_data
    );

endinterface : vga_write_ctrl_if
`default_nettype wire

// File: rtl/vga_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : vga_fill_engine
// Description : Rectangle-fill engine. Walks a w x h box in raster order
//               (x fastest) and presents one pixel request per cycle while
//               in RUN; a stalled cycle leaves every counter untouched.
//   clk50M, rst        : clock, async active-high reset
//   start, op_*        : start pulse and operands (sampled on the same edge)
//   stall              : pixel slot taken by someone else this cycle
//   req, addr, data    : current pixel request
//   busy, done         : RUN or DONE / one-cycle completion pulse
// Config      : VGA_FILL_CLIP_EN - clip the box to the 400x300 screen
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fill_engine
    import vga_write_ctrl_pkg::*;
(
    input  wire logic                      clk50M,
    input  wire logic                      rst,
    input  wire logic                      start,
    input  wire logic [FILL_CW-1:0]        op_x,
    input  wire logic [FILL_CW-1:0]        op_y,
    input  wire logic [FILL_CW-1:0]        op_w,
    input  wire logic [FILL_CW-1:0]        op_h,
    input  wire logic [VGA_DATA_WIDTH-1:0] op_color,
    input  wire logic                      stall,
    output logic                           req,
    output logic [VGA_ADDR_WIDTH-1:0]      addr,
    output logic [VGA_DATA_WIDTH-1:0]      data,
    output logic                           busy,
    output logic                           done
);

    fill_state_t        r_state;
    fill_state_t        w_state_nxt;
    fill_op_t           r_op;
    logic [FILL_CW-1:0] r_col;
    logic [FILL_CW-1:0] r_row;

    logic [FILL_CW-1:0] w_eff_w;
    logic [FILL_CW-1:0] w_eff_h;
    logic               w_nonempty;
    logic               w_accept;
    logic               w_adv;
    logic               w_col_end;
    logic               w_last;

    // ------------------------------------------------------------------
    // Effective rectangle size at start
    // ------------------------------------------------------------------
`ifdef VGA_FILL_CLIP_EN
    logic [FILL_CW:0] w_room_x;
    logic [FILL_CW:0] w_room_y;

    always_comb begin
        // Remaining screen to the right of / below the corner; zero when
        // the corner itself is off-screen, which empties the box.
        w_room_x = ({1'b0, op_x} >= (FILL_CW+1)'(VGA_FB_W)) ? '0
                 : (FILL_CW+1)'(VGA_FB_W) - {1'b0, op_x};
        w_room_y = ({1'b0, op_y} >= (FILL_CW+1)'(VGA_FB_H)) ? '0
                 : (FILL_CW+1)'(VGA_FB_H) - {1'b0, op_y};
        w_eff_w  = ({1'b0, op_w} > w_room_x) ? w_room_x[FILL_CW-1:0] : op_w;
        w_eff_h  = ({1'b0, op_h} > w_room_y) ? w_room_y[FILL_CW-1:0] : op_h;
    end
`else
    always_comb begin
        w_eff_w = op_w;
        w_eff_h = op_h;
    end
`endif

    assign w_nonempty = (w_eff_w != '0) && (w_eff_h != '0);
    assign w_accept   = (r_state == VGA_FILL_IDLE) && start;
    assign w_adv      = (r_state == VGA_FILL_RUN) && !stall;
    assign w_col_end  = (r_col == r_op.w - 9'd1);
    assign w_last     = w_col_end && (r_row == r_op.h - 9'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_state <= VGA_FILL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            VGA_FILL_IDLE: begin
                if (start) begin
                    w_state_nxt = w_nonempty ? VGA_FILL_RUN : VGA_FILL_DONE;
                end
            end
            VGA_FILL_RUN: begin
                if (w_adv && w_last) begin
                    w_state_nxt = VGA_FILL_DONE;
                end
            end
            VGA_FILL_DONE: begin
                w_state_nxt = VGA_FILL_IDLE;
            end
            default: begin
                w_state_nxt = VGA_FILL_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req  = (r_state == VGA_FILL_RUN);
        busy = (r_state == VGA_FILL_RUN) || (r_state == VGA_FILL_DONE);
        done = (r_state == VGA_FILL_DONE);
        addr = fill_addr(r_op.y, r_row, r_op.x, r_col);
        data = r_op.color;
    end

    // ------------------------------------------------------------------
    // Operand latch and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_op  <= '{x: op_x, y: op_y, w: w_eff_w, h: w_eff_h, color: op_color};
            r_col <= '0;
            r_row <= '0;
        end else if (w_adv) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 9'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end
    end

endmodule : vga_fill_engine
`default_nettype wire

// File: rtl/vga_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_ctrl
// Description : Shares the single vga framebuffer write port between CPU
//               pixel writes and the rectangle-fill engine. CPU writes always
//               win the slot and stall the engine; the winning write is
//               registered and shown on vga_* for exactly one cycle.
//   clk50M : system clock (same as vga)
//   rst    : async active-high reset
//   bus    : vga_write_ctrl_if.slave (CPU write, fill request/status,
//            registered vga write port)
// Config      : VGA_FILL_CLIP_EN - clip fills to the 400x300 screen
// Revision    : 1.0 - initial release
// ============================================================================
module vga_write_ctrl
    import vga_write_ctrl_pkg::*;
(
    input  wire logic        clk50M,
    input  wire logic        rst,
    vga_write_ctrl_if.slave  bus
);

    logic                      w_fill_req;
    logic [VGA_ADDR_WIDTH-1:0] w_fill_addr;
    logic [VGA_DATA_WIDTH-1:0] w_fill_data;

    logic                      w_sel_we;
    logic [VGA_ADDR_WIDTH-1:0] w_sel_addr;
    logic [VGA_DATA_WIDTH-1:0] w_sel_data;

    logic                      r_vga_we;
    logic [VGA_ADDR_WIDTH-1:0] r_vga_addr;
    logic [VGA_DATA_WIDTH-1:0] r_vga_data;

    vga_fill_engine u_fill (
        .clk50M   (clk50M),
        .rst      (rst),
        .start    (bus.fill_start),
        .op_x     (bus.fill_x),
        .op_y     (bus.fill_y),
        .op_w     (bus.fill_w),
        .op_h     (bus.fill_h),
        .op_color (bus.fill_color),
        .stall    (bus.cpu_we),
        .req      (w_fill_req),
        .addr     (w_fill_addr),
        .data     (w_fill_data),
        .busy     (bus.fill_busy),
        .done     (bus.fill_done)
    );

    // CPU has no backpressure, so it takes the slot unconditionally and the
    // engine (stalled by the same cpu_we) simply retries next cycle.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = w_fill_addr;
        w_sel_data = w_fill_data;
        if (bus.cpu_we) begin
            w_sel_we   = 1'b1;
            w_sel_addr = bus.cpu_addr;
            w_sel_data = bus.cpu_data;
        end else if (w_fill_req) begin
            w_sel_we   = 1'b1;
        end
    end

    // Address/data only move on a real write; they hold otherwise.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_vga_we   <= 1'b0;
            r_vga_addr <= '0;
            r_vga_data <= '0;
        end else begin
            r_vga_we <= w_sel_we;
            if (w_sel_we) begin
                r_vga_addr <= w_sel_addr;
                r_vga_data <= w_sel_data;
            end
        end
    end

    assign bus.vga_we   = r_vga_we;
    assign bus.vga_addr = r_vga_addr;
    assign bus.vga_data = r_vga_data;

endmodule : vga_write_ctrl
`default_nettype wire

// File: tb/tb_vga_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_write_ctrl
// Description : Directed self-checking bench for vga_write_ctrl. Inputs are
//               driven 1 time unit after each rising edge; outputs are
//               sampled at the same point, i.e. they show what the previous
//               edge registered.
// Config      : VGA_FILL_CLIP_EN selects the clipped-fill expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_write_ctrl;
    import vga_write_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_write_ctrl_if bus ();

    vga_write_ctrl dut (
        .clk50M (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Expected fill address streams (stride 512)
    int unsigned fill_a [6]  = '{1034, 1035, 1036, 1546, 1547, 1548};
    int unsigned mix_a  [8]  = '{1034, 'hAAA, 'hBBB, 1035, 1036, 1546, 1547, 1548};
    int unsigned mix_d  [8]  = '{'h1C, 'h55, 'h66, 'h1C, 'h1C, 'h1C, 'h1C, 'h1C};
    int unsigned edge_a [5]  = '{153486, 153487, 153488, 153489, 153490};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic we, input logic busy, input logic done);
        chk({tag, ".we"},   32'(bus.vga_we),    32'(we));
        chk({tag, ".busy"}, 32'(bus.fill_busy), 32'(busy));
        chk({tag, ".done"}, 32'(bus.fill_done), 32'(done));
    endtask

    task automatic chk_wr(input string tag, input int unsigned addr, input int unsigned data);
        chk({tag, ".addr"}, 32'(bus.vga_addr), addr);
        chk({tag, ".data"}, 32'(bus.vga_data), data);
    endtask

    task automatic cpu(input logic we, input int unsigned addr, input int unsigned data);
        bus.cpu_we   = we;
        bus.cpu_addr = VGA_ADDR_WIDTH'(addr);
        bus.cpu_data = VGA_DATA_WIDTH'(data);
    endtask

    task automatic fill(input int x, input int y, input int w, input int h, input int color);
        bus.fill_start = 1'b1;
        bus.fill_x     = 9'(x);
        bus.fill_y     = 9'(y);
        bus.fill_w     = 9'(w);
        bus.fill_h     = 9'(h);
        bus.fill_color = 8'(color);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu(1'b0, 0, 0);
        fill(0, 0, 0, 0, 0);
        bus.fill_start = 1'b0;

        // Reset held, then 10 idle cycles
        repeat (2) tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_wr("reset", 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_ctl("idle", 1'b0, 1'b0, 1'b0);
            chk_wr("idle", 0, 0);
        end

        // Single CPU write, visible one cycle only
        cpu(1'b1, 'h123, 'hE0);
        tick();
        cpu(1'b0, 0, 0);
        chk_ctl("cpu", 1'b1, 1'b0, 1'b0);
        chk_wr("cpu", 'h123, 'hE0);
        tick();
        chk_ctl("cpu_after", 1'b0, 1'b0, 1'b0);

        // Plain fill 3x2 at (10,2): 6 consecutive writes, 7 busy cycles
        fill(10, 2, 3, 2, 'h1C);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("fill_start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_ctl("fill_px", 1'b1, 1'b1, i == 5);
            chk_wr("fill_px", fill_a[i], 'h1C);
        end
        tick();
        chk_ctl("fill_end", 1'b0, 1'b0, 1'b0);

        // Same fill, CPU steals busy cycles 2 and 3
        fill(10, 2, 3, 2, 'h1C);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("mix_start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cpu((i == 1) || (i == 2), mix_a[i], mix_d[i]);
            tick();
            chk_ctl("mix_px", 1'b1, 1'b1, i == 7);
            chk_wr("mix_px", mix_a[i], mix_d[i]);
        end
        cpu(1'b0, 0, 0);
        tick();
        chk_ctl("mix_end", 1'b0, 1'b0, 1'b0);

        // Start while busy is ignored
        fill(0, 0, 2, 1, 'h33);
        tick();
        fill(100, 100, 4, 4, 'h77);
        chk_ctl("ign_start", 1'b0, 1'b1, 1'b0);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("ign_px0", 1'b1, 1'b1, 1'b0);
        chk_wr("ign_px0", 0, 'h33);
        tick();
        chk_ctl("ign_px1", 1'b1, 1'b1, 1'b1);
        chk_wr("ign_px1", 1, 'h33);
        tick();
        chk_ctl("ign_end", 1'b0, 1'b0, 1'b0);

        // Empty boxes: straight to DONE, no writes
        fill(5, 5, 0, 5, 'hFF);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("w0_done", 1'b0, 1'b1, 1'b1);
        tick();
        chk_ctl("w0_end", 1'b0, 1'b0, 1'b0);
        fill(5, 5, 5, 0, 'hFF);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("h0_done", 1'b0, 1'b1, 1'b1);
        tick();
        chk_ctl("h0_end", 1'b0, 1'b0, 1'b0);

        // Start and CPU write on the same edge: both honoured
        fill(7, 1, 1, 1, 'h42);
        cpu(1'b1, 'h3, 'h99);
        tick();
        bus.fill_start = 1'b0;
        cpu(1'b0, 0, 0);
        chk_ctl("both_cpu", 1'b1, 1'b1, 1'b0);
        chk_wr("both_cpu", 'h3, 'h99);
        tick();
        chk_ctl("both_px", 1'b1, 1'b1, 1'b1);
        chk_wr("both_px", 519, 'h42);
        tick();
        chk_ctl("both_end", 1'b0, 1'b0, 1'b0);

`ifdef VGA_FILL_CLIP_EN
        // Corner box clipped to 2x1
        fill(398, 299, 5, 5, 'hAB);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("clip_start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_ctl("clip_px", 1'b1, 1'b1, i == 1);
            chk_wr("clip_px", edge_a[i], 'hAB);
        end
        tick();
        chk_ctl("clip_end", 1'b0, 1'b0, 1'b0);
        // Corner off-screen: empty
        fill(400, 10, 5, 5, 'hAB);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("clip_off", 1'b0, 1'b1, 1'b1);
        tick();
        chk_ctl("clip_off_end", 1'b0, 1'b0, 1'b0);
`else
        // Unclipped: columns past 400 continue into stride padding
        fill(398, 299, 5, 1, 'hAB);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("edge_start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ctl("edge_px", 1'b1, 1'b1, i == 4);
            chk_wr("edge_px", edge_a[i], 'hAB);
        end
        tick();
        chk_ctl("edge_end", 1'b0, 1'b0, 1'b0);
`endif

        // Reset mid-fill: outputs clear at once, no done, restart works
        fill(10, 2, 3, 2, 'h1C);
        tick();
        bus.fill_start = 1'b0;
        tick();
        chk_ctl("rst_pre", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_ctl("rst_async", 1'b0, 1'b0, 1'b0);
        chk_wr("rst_async", 0, 0);
        tick();
        rst = 1'b0;
        chk_ctl("rst_hold", 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("rst_after", 1'b0, 1'b0, 1'b0);
        fill(5, 0, 1, 1, 'h0F);
        tick();
        bus.fill_start = 1'b0;
        chk_ctl("re_start", 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl("re_px", 1'b1, 1'b1, 1'b1);
        chk_wr("re_px", 5, 'h0F);
        tick();
        chk_ctl("re_end", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vga_write_ctrl
`default_nettype wire
